// File: rtl/nf_run_ctrl.sv
// nanoFOX run control: programmable cpu_en divider with halt, single-step,
// resume, address breakpoints and a saturating strobe counter.

module nf_bp_cmp #(
  parameter int ADDR_W = 32
) (
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] pc,
  output logic              hit
);
  assign hit = en && (addr == pc);
endmodule

module nf_run_ctrl #(
  parameter int DIV_W        = 26,
  parameter int ADDR_W       = 32,
  parameter int NUM_BP       = 2,
  parameter int CNT_W        = 32,
  parameter bit START_HALTED = 1'b0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [DIV_W-1:0]               div,
  input  logic                           halt_req,
  input  logic                           resume,
  input  logic                           step_req,
  input  logic [NUM_BP-1:0]              bp_en,
  input  logic [NUM_BP-1:0][ADDR_W-1:0]  bp_addr,
  input  logic [ADDR_W-1:0]              instr_addr,
  input  logic                           cnt_clr,
  output logic                           cpu_en,
  output logic                           halted,
  output logic [NUM_BP-1:0]              bp_hit,
  output logic [CNT_W-1:0]               strobe_cnt
);
  typedef enum logic [1:0] {RUN, HALT, STEP} state_t;
  localparam state_t RST_STATE = START_HALTED ? HALT : RUN;

  state_t            state, state_nxt;
  logic [DIV_W-1:0]  dcnt;
  logic              tick, grant, skip, skip_nxt;
  logic [NUM_BP-1:0] match, bp_hit_nxt;

  for (genvar i = 0; i < NUM_BP; i++) begin : g_bp
    nf_bp_cmp #(.ADDR_W(ADDR_W)) u_cmp (
      .en   (bp_en[i]),
      .addr (bp_addr[i]),
      .pc   (instr_addr),
      .hit  (match[i])
    );
  end

  // >= rather than == so lowering div below the count ticks at once
  assign tick   = (dcnt >= div);
  assign halted = (state == HALT);

  always_ff @(posedge clk) begin
    if (reset) dcnt <= '0;
    else       dcnt <= tick ? '0 : dcnt + 1'b1;
  end

  always_comb begin
    state_nxt  = state;
    grant      = 1'b0;
    skip_nxt   = skip;
    bp_hit_nxt = bp_hit;
    unique case (state)
      RUN: begin
        if (halt_req) begin
          state_nxt = HALT;
        end else if (tick) begin
          if (|match && !skip) begin
            state_nxt  = HALT;
            bp_hit_nxt = match;
          end else begin
            grant    = 1'b1;
            skip_nxt = 1'b0;
          end
        end
      end
      HALT: begin
        // skip lets the first strobe out of HALT run the breakpointed instruction
        if (step_req || (resume && !halt_req)) begin
          state_nxt  = step_req ? STEP : RUN;
          skip_nxt   = 1'b1;
          bp_hit_nxt = '0;
        end
      end
      STEP: begin
        if (tick) begin
          grant     = 1'b1;
          skip_nxt  = 1'b0;
          state_nxt = HALT;
        end
      end
      default: state_nxt = RST_STATE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= RST_STATE;
      skip   <= 1'b0;
      bp_hit <= '0;
      cpu_en <= 1'b0;
    end else begin
      state  <= state_nxt;
      skip   <= skip_nxt;
      bp_hit <= bp_hit_nxt;
      cpu_en <= grant;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || cnt_clr)
      strobe_cnt <= '0;
    else if (cpu_en && (strobe_cnt != {CNT_W{1'b1}}))
      strobe_cnt <= strobe_cnt + 1'b1;
  end
endmodule

// File: tb/tb_nf_run_ctrl.sv
// Bench for nf_run_ctrl: directed scenarios plus random traffic, all checked
// every cycle against a behavioural model of the run-control rules.
module tb_nf_run_ctrl;
  localparam int DIV_W = 26, ADDR_W = 32, NUM_BP = 2, CNT_W = 4;
  localparam bit START_HALTED = 1'b0;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [DIV_W-1:0] div = '0;
  logic halt_req = 1'b0, resume = 1'b0, step_req = 1'b0, cnt_clr = 1'b0;
  logic [NUM_BP-1:0] bp_en = '0;
  logic [NUM_BP-1:0][ADDR_W-1:0] bp_addr = '0;
  logic [ADDR_W-1:0] instr_addr = '0;
  logic cpu_en, halted;
  logic [NUM_BP-1:0] bp_hit;
  logic [CNT_W-1:0] strobe_cnt;

  int checks = 0, failures = 0;
  bit follow = 1'b0;
  int pulses;

  nf_run_ctrl #(.DIV_W(DIV_W), .ADDR_W(ADDR_W), .NUM_BP(NUM_BP), .CNT_W(CNT_W),
                .START_HALTED(START_HALTED)) dut (
    .clk(clk), .reset(reset), .div(div), .halt_req(halt_req), .resume(resume),
    .step_req(step_req), .bp_en(bp_en), .bp_addr(bp_addr), .instr_addr(instr_addr),
    .cnt_clr(cnt_clr), .cpu_en(cpu_en), .halted(halted), .bp_hit(bp_hit),
    .strobe_cnt(strobe_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model: CPU is "running", "stepping" or neither (halted).
  bit armed = 1'b0;
  bit m_run, m_step, m_skip, m_en, m_tick, m_grant;
  logic [NUM_BP-1:0] m_hit, m_match;
  int unsigned m_since;
  int m_scnt;

  initial forever begin
    @(posedge clk);
    if (reset) begin
      m_since = 0; m_run = !START_HALTED; m_step = 0; m_skip = 0;
      m_en = 0; m_hit = '0; m_scnt = 0; armed = 1;
    end else begin
      m_tick  = (m_since >= div);
      m_grant = 0;
      for (int i = 0; i < NUM_BP; i++)
        m_match[i] = bp_en[i] && (bp_addr[i] == instr_addr);
      if (cnt_clr) m_scnt = 0;
      else if (m_en && m_scnt < CNT_MAX) m_scnt++;
      if (m_step) begin
        if (m_tick) begin m_grant = 1; m_step = 0; m_skip = 0; end
      end else if (m_run) begin
        if (halt_req) m_run = 0;
        else if (m_tick) begin
          if (m_match != 0 && !m_skip) begin m_run = 0; m_hit = m_match; end
          else begin m_grant = 1; m_skip = 0; end
        end
      end else begin
        if (step_req) begin m_step = 1; m_skip = 1; m_hit = '0; end
        else if (resume && !halt_req) begin m_run = 1; m_skip = 1; m_hit = '0; end
      end
      m_since = m_tick ? 0 : m_since + 1;
      m_en = m_grant;
    end
  end

  initial forever begin
    @(negedge clk);
    if (armed) begin
      chk("cpu_en", 64'(cpu_en), 64'(m_en));
      chk("halted", 64'(halted), 64'(!m_run && !m_step));
      chk("bp_hit", 64'(bp_hit), 64'(m_hit));
      chk("strobe_cnt", 64'(strobe_cnt), 64'(m_scnt));
    end
  end

  // The bench plays the CPU: its PC advances by 4 after each granted strobe.
  task automatic cyc();
    bit e;
    e = m_en;
    @(posedge clk); #1;
    if (follow && e) instr_addr = instr_addr + 32'd4;
  endtask

  task automatic do_reset();
    reset = 1'b1; cyc(); reset = 1'b0;
  endtask

  task automatic run_count(input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      if (cpu_en) pulses++;
    end
  endtask

  initial begin
    // reset state
    div = 26'd3;
    cyc();
    chk("rst_cpu_en", 64'(cpu_en), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_bp_hit", 64'(bp_hit), 64'd0);
    chk("rst_cnt", 64'(strobe_cnt), 64'd0);
    reset = 1'b0;

    // free run, div=3
    pulses = 0;
    run_count(41);
    chk("free_pulses", 64'(pulses), 64'd10);
    chk("free_cnt", 64'(strobe_cnt), 64'd10);
    chk("free_halted", 64'(halted), 64'd0);

    // breakpoint at 0x10, then resume past it
    do_reset();
    follow = 1'b1; instr_addr = '0;
    bp_en = 2'b01; bp_addr[0] = 32'h10; bp_addr[1] = 32'h10;
    for (int i = 0; i < 100 && !halted; i++) cyc();
    chk("bp_halted", 64'(halted), 64'd1);
    chk("bp_pc", 64'(instr_addr), 64'h10);
    chk("bp_hit_vec", 64'(bp_hit), 64'b01);
    chk("bp_cnt", 64'(strobe_cnt), 64'd4);
    resume = 1'b1; cyc(); resume = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    chk("resume_pc", 64'(instr_addr), 64'h18);
    chk("resume_halted", 64'(halted), 64'd0);
    chk("resume_hit", 64'(bp_hit), 64'd0);
    chk("resume_cnt", 64'(strobe_cnt), 64'd6);

    // single step at div=0
    div = 26'd0; bp_en = '0;
    do_reset();
    halt_req = 1'b1; cyc(); halt_req = 1'b0;
    chk("step_pre_halted", 64'(halted), 64'd1);
    pulses = 0;
    step_req = 1'b1; cyc(); step_req = 1'b0;
    run_count(4);
    chk("step_pulses", 64'(pulses), 64'd1);
    chk("step_halted", 64'(halted), 64'd1);
    pulses = 0;
    step_req = 1'b1; resume = 1'b1; cyc(); step_req = 1'b0; resume = 1'b0;
    run_count(4);
    chk("step_res_pulses", 64'(pulses), 64'd1);
    chk("step_res_halted", 64'(halted), 64'd1);

    // halt_req in a tick cycle, div=5
    div = 26'd5;
    do_reset();
    for (int i = 0; i < 5; i++) cyc();
    halt_req = 1'b1; cyc();
    chk("halt_tick_en", 64'(cpu_en), 64'd0);
    chk("halt_tick_halted", 64'(halted), 64'd1);
    resume = 1'b1; cyc(); resume = 1'b0; cyc();
    chk("resume_blocked", 64'(halted), 64'd1);
    halt_req = 1'b0;

    // counter saturation and clear
    div = 26'd0;
    do_reset();
    for (int i = 0; i < 20; i++) cyc();
    chk("cnt_sat", 64'(strobe_cnt), 64'd15);
    cnt_clr = 1'b1; cyc(); cnt_clr = 1'b0;
    chk("clr_en", 64'(cpu_en), 64'd1);
    chk("clr_cnt", 64'(strobe_cnt), 64'd0);

    // reset aborts a pending step
    div = 26'd7;
    do_reset();
    halt_req = 1'b1; cyc(); halt_req = 1'b0;
    step_req = 1'b1; cyc(); step_req = 1'b0;
    reset = 1'b1; cyc(); reset = 1'b0;
    chk("abort_en", 64'(cpu_en), 64'd0);
    chk("abort_halted", 64'(halted), 64'd0);
    chk("abort_hit", 64'(bp_hit), 64'd0);
    chk("abort_cnt", 64'(strobe_cnt), 64'd0);
    pulses = 0;
    run_count(7);
    chk("abort_pulses", 64'(pulses), 64'd0);

    // random traffic
    div = 26'd2; instr_addr = '0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) < 3) halt_req = ~halt_req;
      resume   = ($urandom_range(0, 19) == 0);
      step_req = ($urandom_range(0, 19) == 0);
      cnt_clr  = ($urandom_range(0, 63) == 0);
      reset    = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 99) == 0) div = DIV_W'($urandom_range(0, 5));
      if ($urandom_range(0, 39) == 0) begin
        bp_en = NUM_BP'($urandom_range(0, 3));
        bp_addr[0] = instr_addr + 32'(4 * $urandom_range(0, 4));
        bp_addr[1] = instr_addr + 32'(4 * $urandom_range(0, 4));
      end
      cyc();
    end
    resume = 1'b0; step_req = 1'b0; cnt_clr = 1'b0; reset = 1'b0;
    cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
